mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation MIPS datapath, replacing the externally driven PC of the single-cycle datapath. Owns the program counter and issues in-order requests to instruction memory with back-pressure. Buffers returned words with their PCs in an instruction fetch queue (IFQ) and hands them to decode over a valid/ready handshake. Branch/jump redirects flush in-flight work and restart fetch at the new target.

---
 rtl/mips_fetch_pkg.sv | 14 +
 rtl/mips_ifq.sv | 67 ++++++
 rtl/mips_fetch_unit.sv | 128 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // One IFQ slot: fetched word plus the PC it was fetched from.
  typedef struct packed {
    logic [31:0]             data;
    logic [XLEN_DEFAULT-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/mips_ifq.sv
// Instruction fetch queue: circular FIFO with flush priority over push/pop.
module mips_ifq
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = ifq_entry_t,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output entry_t        head_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited in-order
// memory requests, buffers responses in the IFQ and handles redirects.
// Optional macro MIPS_FETCH_BYPASS_EN: zero-latency bypass of a kept response
// straight to decode while the IFQ is empty.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned      PC_STEP   = DEFAULT_PC_STEP,
  parameter int unsigned      IFQ_DEPTH = 4,
  localparam int unsigned     CW        = $clog2(IFQ_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_pc_next_o,
  output logic [CW-1:0]   ifq_count_o
);

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(IFQ_DEPTH);

  logic            run_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   ifq_count;
  logic [CW:0]     inflight;
  entry_t          ifq_head, rsp_entry, sel;
  logic            req_fire, rsp_legal, rsp_keep, bypass, ifq_push, ifq_pop;

  // Request credit, response classification and decode-side selection.
  always_comb begin
    inflight         = {1'b0, ifq_count} + {1'b0, outstanding_q};
    imem_req_valid_o = run_q && !redirect_valid_i && (inflight < DEPTH_W);
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_legal        = imem_rsp_valid_i && (outstanding_q != '0);
    rsp_keep         = rsp_legal && (drop_q == '0) && !redirect_valid_i;
    rsp_entry        = '{data: imem_rsp_data_i, pc: rsp_pc_q};
`ifdef MIPS_FETCH_BYPASS_EN
    bypass           = rsp_keep && (ifq_count == '0);
`else
    bypass           = 1'b0;
`endif
    sel              = bypass ? rsp_entry : ifq_head;
    inst_valid_o     = bypass || (ifq_count != '0);
    inst_data_o      = inst_valid_o ? sel.data : '0;
    inst_pc_o        = inst_valid_o ? sel.pc : '0;
    inst_pc_next_o   = inst_valid_o ? (sel.pc + STEP) : '0;
    // A bypassed word consumed this cycle never occupies a slot.
    ifq_push         = rsp_keep && !(bypass && inst_ready_i);
    ifq_pop          = inst_ready_i && (ifq_count != '0);
  end

  // Next-state for PCs and request/drop bookkeeping; redirect dominates.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_legal);
    drop_d        = drop_q;
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i;
      rsp_pc_d = redirect_pc_i;
      // Every request still unanswered after this cycle is stale.
      drop_d   = outstanding_q - CW'(rsp_legal);
    end else begin
      if (req_fire)                     pc_d     = pc_q + STEP;
      if (rsp_keep)                     rsp_pc_d = rsp_pc_q + STEP;
      if (rsp_legal && drop_q != '0)    drop_d   = drop_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      run_q         <= 1'b1;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  mips_ifq #(
    .DEPTH   (IFQ_DEPTH),
    .entry_t (entry_t)
  ) u_ifq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (ifq_push),
    .push_data_i (rsp_entry),
    .pop_i       (ifq_pop),
    .flush_i     (redirect_valid_i),
    .count_o     (ifq_count),
    .head_o      (ifq_head)
  );

  assign imem_req_addr_o = pc_q;
  assign ifq_count_o     = ifq_count;

  // A response with nothing outstanding is a memory-side protocol error.
  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(imem_rsp_valid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a latency-configurable memory model
// and an expected-instruction scoreboard.
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, inst_pc_next;
  logic [2:0]  ifq_count;

  logic        r1_valid, r1_ready, r1_rsp_valid, r1_redir, r1_inst_valid, r1_inst_ready;
  logic [31:0] r1_addr, r1_rsp_data, r1_redir_pc, r1_inst_data, r1_inst_pc, r1_inst_pc_next;
  logic [2:0]  r1_count;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          cyc, lat, errors, checks, n_req, n_inst, n1, exp_drop;
  logic [31:0] m_pc, m1_pc, first_tgt;
  logic        pending_first, redir_fire, last_req_valid, last_inst_valid;

  mips_fetch_unit dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_valid_i(redir_valid), .redirect_pc_i(redir_pc),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_data_o(inst_data),
    .inst_pc_o(inst_pc), .inst_pc_next_o(inst_pc_next), .ifq_count_o(ifq_count)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(r1_valid), .imem_req_ready_i(r1_ready), .imem_req_addr_o(r1_addr),
    .imem_rsp_valid_i(r1_rsp_valid), .imem_rsp_data_i(r1_rsp_data),
    .redirect_valid_i(r1_redir), .redirect_pc_i(r1_redir_pc),
    .inst_valid_o(r1_inst_valid), .inst_ready_i(r1_inst_ready), .inst_data_o(r1_inst_data),
    .inst_pc_o(r1_inst_pc), .inst_pc_next_o(r1_inst_pc_next), .ifq_count_o(r1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive memory response/redirect at the falling edge, check
  // and update the models, then return just after the rising edge.
  task automatic step(input logic rdir, input logic [31:0] tgt, input logic cond,
                      output logic took);
    logic rf, inf;
    exp_t e;
    @(negedge clk);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1; rsp_data = memfn(mem_q[0].addr);
    end else begin
      rsp_valid = 1'b0; rsp_data = '0;
    end
    redir_valid = rdir; redir_pc = tgt;
    #1;
    if (cond && rsp_valid && inst_valid) begin redir_valid = 1'b1; #1; end
    took            = redir_valid;
    last_req_valid  = req_valid;
    last_inst_valid = inst_valid;
    rf  = req_valid && req_ready;
    inf = inst_valid && inst_ready;
    if (req_valid)   chk("req_addr", req_addr, m_pc);
    if (redir_valid) chk("no_req_on_redirect", req_valid, 1'b0);
    if (inf) begin
      chk("inst_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_data", inst_data, e.data);
        chk("inst_pc_next", inst_pc_next, e.pc + 32'd4);
        if (pending_first && !redir_valid) begin
          chk("first_pc_after_redirect", inst_pc, first_tgt);
          pending_first = 1'b0;
        end
      end
      n_inst++;
    end
    if (redir_valid) begin
      exp_drop      = mem_q.size() - (rsp_valid ? 1 : 0);
      redir_fire    = inf;
      exp_q.delete();
      m_pc          = redir_pc;
      pending_first = 1'b1;
      first_tgt     = redir_pc;
    end
    if (rsp_valid) void'(mem_q.pop_front());
    if (rf) begin
      mem_q.push_back('{addr: req_addr, due: cyc + lat});
      if (!redir_valid) begin
        exp_q.push_back('{data: memfn(m_pc), pc: m_pc});
        m_pc += 32'd4;
      end
      n_req++;
    end
    if (r1_valid) begin
      chk("wrap_addr", r1_addr, m1_pc);
      m1_pc += 32'd4;
      n1++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic t;
    int k;
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    k = 0;
    while ((mem_q.size() != 0 || exp_q.size() != 0 || ifq_count != 0) && k < 60) begin
      step(1'b0, '0, 1'b0, t);
      k++;
    end
    chk("drain_done", (mem_q.size() == 0 && exp_q.size() == 0 && ifq_count == 0), 1'b1);
  endtask

  initial begin
    logic t;
    int   base, k;
    errors = 0; checks = 0; cyc = 0; n_req = 0; n_inst = 0; n1 = 0; exp_drop = 0;
    m_pc = 32'h0; m1_pc = 32'hFFFF_FFF8; first_tgt = '0;
    pending_first = 1'b0; redir_fire = 1'b0; last_req_valid = 1'b0; last_inst_valid = 1'b0;
    rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b0; lat = 2;
    r1_ready = 1'b1; r1_rsp_valid = 1'b0; r1_rsp_data = '0; r1_redir = 1'b0;
    r1_redir_pc = '0; r1_inst_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_pc_next", inst_pc_next, 32'h0);
    chk("rst_ifq_count", ifq_count, 3'd0);
    chk("rst_wrap_addr", r1_addr, 32'hFFFF_FFF8);

    // Sequential streaming, 2-cycle memory; wrap instance runs alongside
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_ready = 1'b1; inst_ready = 1'b1; lat = 2;
    step(1'b0, '0, 1'b0, t);
    chk("no_req_before_run", last_req_valid, 1'b0);
    step(1'b0, '0, 1'b0, t);
    chk("first_req", last_req_valid, 1'b1);
    repeat (18) step(1'b0, '0, 1'b0, t);
    chk("A_deliveries", n_inst >= 8, 1'b1);
    chk("wrap_requests", n1, 4);
    drain();

    // Decode stalled: credit limits to IFQ_DEPTH requests
    lat = 1; req_ready = 1'b1; inst_ready = 1'b0; base = n_req;
    repeat (10) step(1'b0, '0, 1'b0, t);
    chk("B_requests", n_req - base, 4);
    chk("B_count_full", ifq_count, 3'd4);
    chk("B_req_blocked", req_valid, 1'b0);
    inst_ready = 1'b1;
    step(1'b0, '0, 1'b0, t);
    chk("B_blocked_until_pop", last_req_valid, 1'b0);
    step(1'b0, '0, 1'b0, t);
    chk("B_req_after_pop", last_req_valid, 1'b1);
    drain();

    // Redirect with three requests outstanding
    lat = 6; req_ready = 1'b1; inst_ready = 1'b1; base = n_req;
    repeat (3) step(1'b0, '0, 1'b0, t);
    chk("C_outstanding", n_req - base, 3);
    step(1'b1, 32'h0000_0100, 1'b0, t);
    chk("C_count_flushed", ifq_count, 3'd0);
    chk("C_new_addr", req_addr, 32'h0000_0100);
    chk("C_drop", dut0.drop_q, 3);
    repeat (20) step(1'b0, '0, 1'b0, t);
    chk("C_first_seen", pending_first, 1'b0);
    drain();

    // Redirect coinciding with a response and an instruction fire
    lat = 3; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (4) step(1'b0, '0, 1'b0, t);
    inst_ready = 1'b1; t = 1'b0; k = 0;
    while (!t && k < 30) begin
      step(1'b0, 32'h0000_0200, 1'b1, t);
      k++;
    end
    chk("D_redirect_taken", t, 1'b1);
    chk("D_fire_consumed", redir_fire, 1'b1);
    chk("D_drop", dut0.drop_q, exp_drop);
    chk("D_count_flushed", ifq_count, 3'd0);
    repeat (15) step(1'b0, '0, 1'b0, t);
    chk("D_first_seen", pending_first, 1'b0);
    drain();

    // Single response into an empty IFQ with decode ready
    lat = 1; inst_ready = 1'b1; req_ready = 1'b1;
    step(1'b0, '0, 1'b0, t);
    req_ready = 1'b0;
    step(1'b0, '0, 1'b0, t);
`ifdef MIPS_FETCH_BYPASS_EN
    chk("E_bypass_valid", last_inst_valid, 1'b1);
    chk("E_bypass_count", ifq_count, 3'd0);
`else
    chk("E_no_bypass_valid", last_inst_valid, 1'b0);
    chk("E_queued_count", ifq_count, 3'd1);
    step(1'b0, '0, 1'b0, t);
    chk("E_valid_next", last_inst_valid, 1'b1);
    chk("E_count_after_pop", ifq_count, 3'd0);
`endif
    drain();

    // Asynchronous reset in the middle of streaming
    lat = 2; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (4) step(1'b0, '0, 1'b0, t);
    @(negedge clk);
    rsp_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_req_addr", req_addr, 32'h0);
    chk("arst_inst_valid", inst_valid, 1'b0);
    chk("arst_ifq_count", ifq_count, 3'd0);
    mem_q.delete(); exp_q.delete();
    m_pc = 32'h0; m1_pc = 32'hFFFF_FFF8; pending_first = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; base = n_inst;
    repeat (10) step(1'b0, '0, 1'b0, t);
    chk("arst_restart_deliveries", n_inst - base >= 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
